multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle control/ALU-control pair.
- An FSM sequences each RV32I-subset instruction through FETCH/DECODE/EXEC/MEM/WB.
- Emits per-state datapath strobes and the ALU control code, and waits on a memory ready handshake.
- Counts retired instructions. Sits between the instruction register / ALU zero flag and the shared multi-cycle datapath.

Parameters:
- INSTRET_W, 32: width of retired-instruction counter.
- ALU_CTL_W, 4: width of alu_ctl (must be >= 4; upper bits zero).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- mem_ready  in  1  memory completed current request
- zero  in  1  ALU zero flag
- mem_req  out  1  memory request
- mem_we  out  1  store when mem_req
- ir_write  out  1  latch instruction and old_pc
- pc_en  out  1  PC register load
- pc_src  out  1  0 = ALU result, 1 = ALUOut (latched target)
- alu_src_a  out  2  00 PC, 01 rs1, 10 zero, 11 old_pc
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- alu_ctl  out  ALU_CTL_W  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 1101 SRA, 0110 SUB, 0111 SLT, 1000 SLTU
- reg_write  out  1  register file write
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC
- illegal_instr  out  1  trap flag
- state  out  3  current FSM state (debug)
- instret  out  INSTRET_W  retired count

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset behaviour:
  - While rst_n=0, every control output is forced to 0.
  - On the reset edge, state becomes FETCH and instret becomes 0.
  - The first cycle after release is FETCH with mem_req=1.
  - Reset mid-instruction aborts immediately: no retire, no strobe.
- Outputs are combinational from state, instr, zero and mem_ready. Unlisted strobes are 0.
- FETCH:
  - mem_req=1, mem_we=0.
  - Holds while mem_ready=0; mem_req stays high.
  - On mem_ready=1: ir_write=1, pc_en=1, pc_src=0, A=PC, B=4, ADD; next state DECODE.
- DECODE:
  - A=old_pc, B=imm, ADD; the branch/jump target is latched in ALUOut.
  - Next state is EXEC if the instruction is legal, else see Optional Feature.
- EXEC:
  - R-type: A=rs1, B=rs2, alu_ctl from funct3/funct7; next WB.
  - I-ALU (0010011): A=rs1, B=imm. SRAI uses funct7[5]. No SUB on the immediate form. Next WB.
  - LUI: A=zero, B=imm, ADD; next WB.
  - LOAD/STORE: A=rs1, B=imm, ADD; next MEM.
  - BRANCH, funct3 000 BEQ / 001 BNE:
    - A=rs1, B=rs2, SUB.
    - pc_src=1, pc_en = zero XOR funct3[0].
    - Retires; next FETCH.
  - JAL: pc_en=1, pc_src=1, reg_write=1, wb_sel=10; retires; next FETCH.
- MEM:
  - mem_req=1, mem_we=(STORE).
  - Holds while mem_ready=0.
  - On ready: LOAD goes to WB; STORE retires and goes to FETCH.
- WB: reg_write=1. wb_sel=01 for LOAD, otherwise 00. Retires; next FETCH.
- Latency with zero-wait memory, in cycles: R/I/LUI 4, LOAD 5, STORE 4, BRANCH/JAL 3.
- Retire: instret increments by 1 on the cycle the FSM leaves to FETCH from a completed instruction. It wraps modulo 2^INSTRET_W.
- mem_ready is ignored outside FETCH and MEM.
- Illegal instructions:
  - Any unlisted opcode.
  - R-type with funct7 not 0000000 or 0100000.
  - funct7 0100000 with funct3 not 000 or 101.
  - BRANCH funct3 not 000 or 001.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction at DECODE moves to TRAP (state 3'b111).
  - illegal_instr=1 and all strobes 0.
  - Held until reset; instret frozen.
- Undefined: an illegal instruction is a NOP.
  - DECODE goes to FETCH.
  - No retire, illegal_instr tied 0.
  - The TRAP state is not compiled.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants;
  - ALU control codes;
  - state encoding: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, TRAP 111;
  - alu_src_a/b and wb_sel encodings.
- One sub-module, alu_decode: combinational class/funct3/funct7 to alu_ctl plus a legal flag. The FSM instantiates it for EXEC.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> all outputs 0, state=000, instret=0. Release -> next cycle mem_req=1.
- instr=0x002081B3 (ADD), mem_ready=1 -> states 000,001,010,100. alu_ctl=0010 in EXEC, reg_write=1 in WB, instret=1.
- instr=0x402081B3 -> EXEC alu_ctl=0110. instr=0x4020D1B3 (SRA) -> alu_ctl=1101.
- instr=0x0000A183 (LW), mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, then WB with wb_sel=01, reg_write=1.
- instr=0x00209463 (BNE):
  - zero=0 -> EXEC pc_en=1, pc_src=1.
  - zero=1 -> pc_en=0.
  - Both cases return to FETCH, instret+1.
- instr opcode 1111111:
  - With macro -> TRAP, illegal_instr=1, persists until rst_n=0.
  - Without macro -> FETCH after DECODE, instret unchanged.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller: opcodes, ALU codes,
// mux selects, FSM states and instruction classes. TRAP exists only with MULTICYCLE_ILLEGAL_TRAP_EN.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_ZERO   = 2'b10;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        , ST_TRAP = 3'b111
`endif
    } state_e;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LUI, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_BAD
    } instr_class_e;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CL_R;
            OP_I:      return CL_I;
            OP_LUI:    return CL_LUI;
            OP_LOAD:   return CL_LOAD;
            OP_STORE:  return CL_STORE;
            OP_BRANCH: return CL_BRANCH;
            OP_JAL:    return CL_JAL;
            default:   return CL_BAD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// Combinational ALU-control decode: instruction class plus funct3/funct7 to a 4-bit
// alu_ctl code and a legality flag for the instruction as a whole.
module alu_decode
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] cls,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctl,
    output logic       legal
);

    // The immediate form never subtracts; funct7[5] only selects SRA over SRL there.
    function automatic logic [3:0] funct3_op(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        alu_ctl = ALU_ADD;
        legal   = 1'b1;
        case (cls)
            CL_R: begin
                alu_ctl = funct3_op(funct3, funct7[5], 1'b1);
                legal   = (funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            CL_I: begin
                alu_ctl = funct3_op(funct3, funct7[5], 1'b0);
            end
            CL_BRANCH: begin
                alu_ctl = ALU_SUB;
                legal   = (funct3[2:1] == 2'b00);
            end
            CL_LUI, CL_LOAD, CL_STORE, CL_JAL: begin
                alu_ctl = ALU_ADD;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with retired-instruction counter.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap on illegal instructions; otherwise they act as NOPs.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32,
    parameter int ALU_CTL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 mem_ready,
    input  logic                 zero,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 illegal_instr,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    instr_class_e           instr_cls;
    logic [3:0]             dec_alu_ctl;
    logic                   dec_legal;
    logic [3:0]             alu_ctl4;
    logic                   retire;
    logic                   unused_instr_bits;

    assign instr_cls         = classify(instr[6:0]);
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    alu_decode u_alu_decode (
        .cls     (instr_cls),
        .funct3  (instr[14:12]),
        .funct7  (instr[31:25]),
        .alu_ctl (dec_alu_ctl),
        .legal   (dec_legal)
    );

    // Reset gates every strobe combinationally so an aborted instruction emits nothing.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_en         = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_ctl4      = ALU_AND;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        illegal_instr = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_en     = 1'b1;
                        alu_src_a = SRC_A_PC;
                        alu_src_b = SRC_B_FOUR;
                        alu_ctl4  = ALU_ADD;
                        state_d   = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                    alu_ctl4  = ALU_ADD;
                    if (dec_legal) begin
                        state_d = ST_EXEC;
                    end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        state_d = ST_FETCH;
`endif
                    end
                end
                ST_EXEC: begin
                    case (instr_cls)
                        CL_R: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_RS2;
                            alu_ctl4  = dec_alu_ctl;
                            state_d   = ST_WB;
                        end
                        CL_I: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                            alu_ctl4  = dec_alu_ctl;
                            state_d   = ST_WB;
                        end
                        CL_LUI: begin
                            alu_src_a = SRC_A_ZERO;
                            alu_src_b = SRC_B_IMM;
                            alu_ctl4  = ALU_ADD;
                            state_d   = ST_WB;
                        end
                        CL_LOAD, CL_STORE: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                            alu_ctl4  = ALU_ADD;
                            state_d   = ST_MEM;
                        end
                        CL_BRANCH: begin
                            // BEQ takes on zero, BNE on not-zero; funct3[0] flips the sense.
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_RS2;
                            alu_ctl4  = ALU_SUB;
                            pc_src    = 1'b1;
                            pc_en     = zero ^ instr[12];
                            retire    = 1'b1;
                            state_d   = ST_FETCH;
                        end
                        CL_JAL: begin
                            pc_en     = 1'b1;
                            pc_src    = 1'b1;
                            reg_write = 1'b1;
                            wb_sel    = WB_PC;
                            retire    = 1'b1;
                            state_d   = ST_FETCH;
                        end
                        default: begin
                            state_d = ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (instr_cls == CL_STORE);
                    if (mem_ready) begin
                        if (instr_cls == CL_STORE) begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (instr_cls == CL_LOAD) ? WB_MDR : WB_ALUOUT;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                ST_TRAP: begin
                    illegal_instr = 1'b1;
                end
`endif
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        alu_ctl      = '0;
        alu_ctl[3:0] = alu_ctl4;
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; expected values are hand-derived.
// Build with MULTICYCLE_ILLEGAL_TRAP_EN to exercise the TRAP path.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        mem_req, mem_we, ir_write, pc_en, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, wb_sel;
    logic [3:0]  alu_ctl;
    logic        reg_write, illegal_instr;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [16:0] ctrl_bus;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.INSTRET_W(32), .ALU_CTL_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .zero          (zero),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .ir_write      (ir_write),
        .pc_en         (pc_en),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ctl       (alu_ctl),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .illegal_instr (illegal_instr),
        .state         (state),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    assign ctrl_bus = {mem_req, mem_we, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                       alu_ctl, reg_write, wb_sel, illegal_instr};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        mem_ready = 1'b1;
        zero      = 1'b0;

        // Reset held three cycles with mem_ready high: strobes must stay off.
        for (int i = 0; i < 3; i++) tick();
        check("rst_ctrl", 32'(ctrl_bus), 32'h0);
        check("rst_state", 32'(state), 32'h0);
        check("rst_instret", instret, 32'h0);

        // ADD x3,x1,x2
        instr = 32'h002081B3;
        rst_n = 1'b1;
        #1;
        check("add_fetch_req", 32'(mem_req), 32'h1);
        check("add_fetch_irw", 32'({ir_write, pc_en, pc_src}), 32'b110);
        check("add_fetch_alu", 32'({alu_src_a, alu_src_b, alu_ctl}), 32'b00_10_0010);
        tick();
        check("add_decode_state", 32'(state), 32'h1);
        check("add_decode_src", 32'({alu_src_a, alu_src_b, alu_ctl}), 32'b11_01_0010);
        tick();
        check("add_exec_state", 32'(state), 32'h2);
        check("add_exec_alu", 32'({alu_src_a, alu_src_b, alu_ctl}), 32'b01_00_0010);
        tick();
        check("add_wb_state", 32'(state), 32'h4);
        check("add_wb_rw", 32'({reg_write, wb_sel}), 32'b1_00);
        check("add_wb_instret", instret, 32'h0);
        tick();
        check("add_retire_state", 32'(state), 32'h0);
        check("add_instret", instret, 32'h1);

        // SUB, SRA, SRAI, ADDI with funct7[5]=1: sample alu_ctl in EXEC.
        instr = 32'h402081B3;
        tick(); tick();
        check("sub_exec", 32'(alu_ctl), 32'h6);
        tick(); tick();
        instr = 32'h4020D1B3;
        tick(); tick();
        check("sra_exec", 32'(alu_ctl), 32'hD);
        tick(); tick();
        instr = 32'h4030D193;
        tick(); tick();
        check("srai_exec", 32'({alu_src_a, alu_src_b, alu_ctl}), 32'b01_01_1101);
        tick(); tick();
        instr = 32'h40308193;
        tick(); tick();
        check("addi_no_sub", 32'(alu_ctl), 32'h2);
        tick(); tick();
        check("alu_seq_instret", instret, 32'h5);

        // FETCH stalls while memory is not ready.
        instr     = 32'h0000A183;
        mem_ready = 1'b0;
        #1;
        check("fetch_wait_req", 32'({mem_req, ir_write, pc_en}), 32'b100);
        tick();
        check("fetch_wait_state", 32'(state), 32'h0);

        // LW with three wait cycles in MEM.
        mem_ready = 1'b1;
        tick(); tick();
        check("lw_exec_alu", 32'({alu_src_a, alu_src_b, alu_ctl}), 32'b01_01_0010);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_wait", 32'({state, mem_req, mem_we}), 32'b011_1_0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("lw_mem_ready", 32'({state, mem_req, mem_we}), 32'b011_1_0);
        tick();
        check("lw_wb", 32'({state, reg_write, wb_sel}), 32'b100_1_01);
        tick();
        check("lw_instret", instret, 32'h6);

        // SW: MEM asserts mem_we and retires straight to FETCH.
        instr = 32'h0020A023;
        tick(); tick(); tick();
        check("sw_mem", 32'({state, mem_req, mem_we, reg_write}), 32'b011_1_1_0);
        tick();
        check("sw_retire", 32'({29'h0, state}), 32'h0);
        check("sw_instret", instret, 32'h7);

        // BNE not taken-zero (branch taken), then zero=1 (not taken); BEQ with zero=1.
        instr = 32'h00209463;
        zero  = 1'b0;
        tick(); tick();
        check("bne_z0", 32'({state, pc_en, pc_src, alu_ctl}), 32'b010_1_1_0110);
        tick();
        check("bne_z0_instret", 32'({instret[3:0], 1'b0, state}), 32'b1000_0_000);
        zero = 1'b1;
        tick(); tick();
        check("bne_z1", 32'({pc_en, pc_src}), 32'b01);
        tick();
        check("bne_z1_instret", instret, 32'h9);
        instr = 32'h00208463;
        tick(); tick();
        check("beq_z1", 32'({pc_en, pc_src}), 32'b11);
        tick();
        zero = 1'b0;

        // JAL
        instr = 32'h008000EF;
        tick(); tick();
        check("jal_exec", 32'({pc_en, pc_src, reg_write, wb_sel}), 32'b1_1_1_10);
        tick();
        check("jal_instret", 32'({instret[7:0], 5'h0, state}), 32'({8'd11, 8'h00}));

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        // Unknown opcode traps and stays trapped until reset.
        instr = 32'h0000007F;
        tick(); tick();
        check("trap_state", 32'(state), 32'h7);
        check("trap_ctrl", 32'(ctrl_bus), 32'h1);
        tick(); tick(); tick();
        check("trap_hold", 32'({state, illegal_instr}), 32'b111_1);
        check("trap_instret", instret, 32'd11);
`else
        // Illegal R-type form and unknown opcode both fall back to FETCH without retiring.
        instr = 32'h402091B3;
        tick(); tick();
        check("illr_nop", 32'({state, illegal_instr}), 32'b000_0);
        instr = 32'h0000007F;
        tick(); tick();
        check("illop_nop", 32'({state, illegal_instr}), 32'b000_0);
        check("ill_instret", instret, 32'd11);
        // Run an ADD into WB so the reset below aborts a pending retire.
        instr = 32'h002081B3;
        tick(); tick(); tick();
        check("abort_pre_wb", 32'({state, reg_write}), 32'b100_1);
`endif

        // Mid-instruction reset: strobes drop at once, no retire, counter clears.
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", 32'(ctrl_bus), 32'h0);
        tick();
        check("abort_state", 32'(state), 32'h0);
        check("abort_instret", instret, 32'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_req", 32'(mem_req), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
